// File: rtl/execute_muldiv.sv
// execute_muldiv: iterative multiply/divide unit beside the execute-stage ALU.
// Owns HI/LO, runs MULT/MULTU/DIV/DIVU over DWIDTH+1 cycles, and serves
// MTHI/MTLO/MFHI/MFLO in a single cycle while idle.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no op in flight; MT/MF served, MULT/DIV accepted
//   CALC  | one shift-add / shift-subtract iteration per cycle
//   FIX   | sign correction, HI/LO write, done pulse

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 6
`endif
`ifndef FUNCT_WIDTH
`define FUNCT_WIDTH 6
`endif
`ifndef RTYPE
`define RTYPE 6'h00
`endif

module execute_muldiv #(
   parameter int DWIDTH    = 32,
   parameter int CNT_WIDTH = $clog2(DWIDTH) + 1
) (
   input  logic                     md_clk,
   input  logic                     md_rst,
   input  logic                     md_i_ce,
   input  logic                     md_i_flush,
   input  logic [`OPCODE_WIDTH-1:0] md_i_opcode,
   input  logic [`FUNCT_WIDTH-1:0]  md_i_funct,
   input  logic [DWIDTH-1:0]        md_i_data_rs,
   input  logic [DWIDTH-1:0]        md_i_data_rt,
   output logic                     md_o_stall,
   output logic                     md_o_busy,
   output logic                     md_o_done,
   output logic [DWIDTH-1:0]        md_o_value,
   output logic                     md_o_ce,
   output logic [DWIDTH-1:0]        md_o_hi,
   output logic [DWIDTH-1:0]        md_o_lo
);

   localparam logic [`FUNCT_WIDTH-1:0] F_MFHI  = `FUNCT_WIDTH'('h10);
   localparam logic [`FUNCT_WIDTH-1:0] F_MTHI  = `FUNCT_WIDTH'('h11);
   localparam logic [`FUNCT_WIDTH-1:0] F_MFLO  = `FUNCT_WIDTH'('h12);
   localparam logic [`FUNCT_WIDTH-1:0] F_MTLO  = `FUNCT_WIDTH'('h13);
   localparam logic [`FUNCT_WIDTH-1:0] F_MULT  = `FUNCT_WIDTH'('h18);
   localparam logic [`FUNCT_WIDTH-1:0] F_MULTU = `FUNCT_WIDTH'('h19);
   localparam logic [`FUNCT_WIDTH-1:0] F_DIV   = `FUNCT_WIDTH'('h1A);
   localparam logic [`FUNCT_WIDTH-1:0] F_DIVU  = `FUNCT_WIDTH'('h1B);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DWIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
   // Multiply: {partial product high, multiplier/product low}.
   // Divide:   {partial remainder, dividend shifting into quotient}.
   logic [2*DWIDTH-1:0]     acc_q, acc_d;
   // Multiplicand magnitude for multiply, divisor magnitude for divide.
   logic [DWIDTH-1:0]       opa_q, opa_d;
   logic                    is_div_q, is_div_d;
   logic                    neg_lo_q, neg_lo_d;
   logic                    neg_hi_q, neg_hi_d;
   logic                    div_zero_q, div_zero_d;
   logic [DWIDTH-1:0]       hi_q, hi_d;
   logic [DWIDTH-1:0]       lo_q, lo_d;
   logic [DWIDTH-1:0]       value_q, value_d;
   logic                    oce_q, oce_d;
   logic                    done_q, done_d;
   logic                    busy_q, busy_d;

   logic                    is_mfhi, is_mthi, is_mflo, is_mtlo;
   logic                    is_mul_op, is_div_op, is_signed_op, is_md;
   logic                    req, accept;
   logic                    sign_rs, sign_rt;
   logic [DWIDTH-1:0]       mag_rs, mag_rt;

   logic [DWIDTH:0]         mul_sum;
   logic [DWIDTH:0]         div_shift;
   logic [DWIDTH:0]         div_diff;
   logic [2*DWIDTH-1:0]     prod;
   logic [DWIDTH-1:0]       quot, rem;

   assign is_mfhi      = (md_i_funct == F_MFHI);
   assign is_mthi      = (md_i_funct == F_MTHI);
   assign is_mflo      = (md_i_funct == F_MFLO);
   assign is_mtlo      = (md_i_funct == F_MTLO);
   assign is_mul_op    = (md_i_funct == F_MULT) | (md_i_funct == F_MULTU);
   assign is_div_op    = (md_i_funct == F_DIV)  | (md_i_funct == F_DIVU);
   assign is_signed_op = (md_i_funct == F_MULT) | (md_i_funct == F_DIV);
   assign is_md        = is_mul_op | is_div_op;

   // Stall depends only on control inputs and busy, never on operands.
   assign req        = md_i_ce & (md_i_opcode == `RTYPE) &
                       (is_md | is_mfhi | is_mthi | is_mflo | is_mtlo);
   assign md_o_stall = req & busy_q & ~md_i_flush;
   assign accept     = req & ~busy_q & ~md_i_flush;

   assign sign_rs = is_signed_op & md_i_data_rs[DWIDTH-1];
   assign sign_rt = is_signed_op & md_i_data_rt[DWIDTH-1];
   assign mag_rs  = sign_rs ? (~md_i_data_rs + 1'b1) : md_i_data_rs;
   assign mag_rt  = sign_rt ? (~md_i_data_rt + 1'b1) : md_i_data_rt;

   // Next-state, iteration datapath and HI/LO/MF result selection.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opa_d      = opa_q;
      is_div_d   = is_div_q;
      neg_lo_d   = neg_lo_q;
      neg_hi_d   = neg_hi_q;
      div_zero_d = div_zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      value_d    = value_q;
      oce_d      = 1'b0;
      done_d     = 1'b0;
      mul_sum    = '0;
      div_shift  = '0;
      div_diff   = '0;
      prod       = '0;
      quot       = '0;
      rem        = '0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_md) begin
                  state_d    = CALC;
                  cnt_d      = '0;
                  is_div_d   = is_div_op;
                  neg_lo_d   = sign_rs ^ sign_rt;
                  neg_hi_d   = is_div_op ? sign_rs : (sign_rs ^ sign_rt);
                  div_zero_d = is_div_op & (md_i_data_rt == '0);
                  if (is_div_op) begin
                     acc_d = {{DWIDTH{1'b0}}, mag_rs};
                     opa_d = mag_rt;
                  end else begin
                     acc_d = {{DWIDTH{1'b0}}, mag_rt};
                     opa_d = mag_rs;
                  end
               end
               if (is_mthi) hi_d = md_i_data_rs;
               if (is_mtlo) lo_d = md_i_data_rs;
               if (is_mfhi) begin
                  value_d = hi_q;
                  oce_d   = 1'b1;
               end
               if (is_mflo) begin
                  value_d = lo_q;
                  oce_d   = 1'b1;
               end
            end
         end
         CALC: begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (is_div_q) begin
               // Restoring step: keep the difference only when it is non-negative.
               div_shift = {acc_q[2*DWIDTH-1:DWIDTH], acc_q[DWIDTH-1]};
               div_diff  = div_shift - {1'b0, opa_q};
               if (!div_diff[DWIDTH]) begin
                  acc_d = {div_diff[DWIDTH-1:0], acc_q[DWIDTH-2:0], 1'b1};
               end else begin
                  acc_d = {div_shift[DWIDTH-1:0], acc_q[DWIDTH-2:0], 1'b0};
               end
            end else begin
               // Add multiplicand into the high half when the multiplier LSB is set, then shift right.
               mul_sum = {1'b0, acc_q[2*DWIDTH-1:DWIDTH]} +
                         {1'b0, (acc_q[0] ? opa_q : {DWIDTH{1'b0}})};
               acc_d   = {mul_sum, acc_q[DWIDTH-1:1]};
            end
            if (cnt_q == CNT_LAST) state_d = FIX;
         end
         FIX: begin
            if (is_div_q) begin
               quot = neg_lo_q ? (~acc_q[DWIDTH-1:0] + 1'b1) : acc_q[DWIDTH-1:0];
               rem  = neg_hi_q ? (~acc_q[2*DWIDTH-1:DWIDTH] + 1'b1)
                               : acc_q[2*DWIDTH-1:DWIDTH];
               // A zero divisor leaves |rs| as remainder; the sign fix restores rs exactly.
               lo_d = div_zero_q ? {DWIDTH{1'b1}} : quot;
               hi_d = rem;
            end else begin
               prod = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
               lo_d = prod[DWIDTH-1:0];
               hi_d = prod[2*DWIDTH-1:DWIDTH];
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Flush abandons any in-flight op without touching HI/LO.
      if (md_i_flush) begin
         state_d = IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         value_d = value_q;
         oce_d   = 1'b0;
         done_d  = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   // FSM state register.
   always_ff @(posedge md_clk or posedge md_rst) begin
      if (md_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Datapath, architectural HI/LO and registered outputs.
   always_ff @(posedge md_clk or posedge md_rst) begin
      if (md_rst) begin
         cnt_q      <= '0;
         acc_q      <= '0;
         opa_q      <= '0;
         is_div_q   <= 1'b0;
         neg_lo_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         value_q    <= '0;
         oce_q      <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opa_q      <= opa_d;
         is_div_q   <= is_div_d;
         neg_lo_q   <= neg_lo_d;
         neg_hi_q   <= neg_hi_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         value_q    <= value_d;
         oce_q      <= oce_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   assign md_o_busy  = busy_q;
   assign md_o_done  = done_q;
   assign md_o_value = value_q;
   assign md_o_ce    = oce_q;
   assign md_o_hi    = hi_q;
   assign md_o_lo    = lo_q;

endmodule
